// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: pad synchroniser, clock deglitch filter,
// 11-bit frame deframer with odd parity check, and a small show-ahead FIFO.
module ps2_rx #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 25000,
    parameter int FIFO_LOG2  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    input  logic       rd_ack,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overflow,
    output logic [1:0] o_dbg_state
);
    localparam int FCW   = $clog2(FILTER_LEN + 1);
    localparam int TCW   = $clog2(TIMEOUT + 1);
    localparam int DEPTH = 1 << FIFO_LOG2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    logic           r_clk_s1, r_clk_s2, r_data_s1, r_data_s2;
    logic           r_filt, r_filt_d, r_fall;
    logic [FCW-1:0] r_fcnt;

    state_t         r_state;
    logic [2:0]     r_bit_cnt;
    logic [7:0]     r_shift;
    logic           r_par_ok;
    logic [TCW-1:0] r_to_cnt;
    logic           r_perr, r_ferr;

    logic [7:0]         r_mem [DEPTH];
    logic [FIFO_LOG2:0] r_wr_ptr, r_rd_ptr;
    logic               r_ovf;

    logic w_empty, w_full, w_push, w_pop, w_wr;

    // Pads idle high, so the synchroniser resets to 1 to avoid a false edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_clk_s1  <= 1'b1;
            r_clk_s2  <= 1'b1;
            r_data_s1 <= 1'b1;
            r_data_s2 <= 1'b1;
        end else begin
            r_clk_s1  <= ps2_clk_in;
            r_clk_s2  <= r_clk_s1;
            r_data_s1 <= ps2_data_in;
            r_data_s2 <= r_data_s1;
        end
    end

    // The filtered clock follows only after FILTER_LEN differing samples in a row.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_filt   <= 1'b1;
            r_filt_d <= 1'b1;
            r_fall   <= 1'b0;
            r_fcnt   <= '0;
        end else begin
            r_filt_d <= r_filt;
            r_fall   <= r_filt_d & ~r_filt;
            if (r_clk_s2 == r_filt) begin
                r_fcnt <= '0;
            end else if (r_fcnt == FCW'(FILTER_LEN - 1)) begin
                r_filt <= r_clk_s2;
                r_fcnt <= '0;
            end else begin
                r_fcnt <= r_fcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_par_ok  <= 1'b0;
            r_to_cnt  <= '0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_perr <= 1'b0;
            r_ferr <= 1'b0;
            if (r_fall) begin
                r_to_cnt <= '0;
                case (r_state)
                    S_IDLE: begin
                        if (!r_data_s2) begin
                            r_bit_cnt <= '0;
                            r_state   <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        r_shift   <= {r_data_s2, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == 3'd7) r_state <= S_PARITY;
                    end
                    S_PARITY: begin
                        r_par_ok <= ^{r_shift, r_data_s2};
                        r_state  <= S_STOP;
                    end
                    S_STOP: begin
                        if (!r_data_s2)    r_ferr <= 1'b1;
                        else if (!r_par_ok) r_perr <= 1'b1;
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end else if (r_state != S_IDLE) begin
                if (r_to_cnt == TCW'(TIMEOUT - 1)) begin
                    r_ferr   <= 1'b1;
                    r_state  <= S_IDLE;
                    r_to_cnt <= '0;
                    r_shift  <= '0;
                end else begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                end
            end else begin
                r_to_cnt <= '0;
            end
        end
    end

    assign w_push = r_fall && (r_state == S_STOP) && r_data_s2 && r_par_ok;

    // Read side: rd_valid means the head is presented on rd_data; rd_ack while
    // rd_valid=1 consumes it and the next head appears the following cycle.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[FIFO_LOG2] != r_rd_ptr[FIFO_LOG2]) &&
                     (r_wr_ptr[FIFO_LOG2-1:0] == r_rd_ptr[FIFO_LOG2-1:0]);
    assign w_pop   = rd_ack && !w_empty;
    assign w_wr    = w_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr[FIFO_LOG2-1:0]] <= r_shift;
    end

    assign rd_data     = w_empty ? 8'h00 : r_mem[r_rd_ptr[FIFO_LOG2-1:0]];
    assign rd_valid    = !w_empty;
    assign parity_err  = r_perr;
    assign frame_err   = r_ferr;
    assign overflow    = r_ovf;
    assign o_dbg_state = r_state;
endmodule

// File: doc/ps2_rx.md
# ps2_rx

Receive-only PS/2 keyboard/mouse interface. It takes the raw `ps2_kclk`/`ps2_kdata` (or `ps2_mclk`/`ps2_mdata`) pad levels, which are asynchronous, and synchronises and deglitches them. It deframes 11-bit PS/2 device-to-host frames, checks parity and stop bit, and buffers good bytes in a small show-ahead FIFO. The `system` block reads that FIFO through a valid/ack handshake. One instance is used per port, clocked from the 25 MHz system clock.

## Interface
Parameters:
- `FILTER_LEN`, 8: consecutive identical synchronised samples needed before the filtered PS/2 clock changes level.
- `TIMEOUT`, 25000: cycles without a filtered falling edge before an in-progress frame is abandoned (1 ms at 25 MHz).
- `FIFO_LOG2`, 2: FIFO depth is 2^FIFO_LOG2 entries (default 4).

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock (clk25MHz).
- `reset` in 1: synchronous, active-high reset.
- `ps2_clk_in` in 1: raw PS/2 clock pad level, asynchronous.
- `ps2_data_in` in 1: raw PS/2 data pad level, asynchronous.
- `rd_data` out 8: byte at the FIFO head, valid while `rd_valid` is 1.
- `rd_valid` out 1: FIFO not empty.
- `rd_ack` in 1: pops the head when `rd_valid` is 1; ignored when `rd_valid` is 0.
- `parity_err` out 1: one-cycle pulse when a frame is rejected for bad parity.
- `frame_err` out 1: one-cycle pulse when a frame is rejected for a bad start/stop bit or a timeout.
- `overflow` out 1: sticky flag, set when a good byte is dropped because the FIFO is full; cleared only by `reset`.

## Operation
- **Synchroniser:** two flops on each of `ps2_clk_in` and `ps2_data_in`.
- **Clock filter:**
  - A counter tracks how long the synchronised clock has differed from the filtered clock.
  - The filtered clock toggles when that counter reaches FILTER_LEN.
  - Any sample equal to the filtered level clears the counter.
  - The filtered clock resets to 1.
- **Edge detect:** `fall` is a registered one-cycle pulse on each 1→0 transition of the filtered clock.
- **Sampling:** on `fall`, the second-stage synchronised data bit is sampled.
- **Deframer FSM** (reset state IDLE):
  - IDLE: on `fall` with data=0 (start bit), clear the bit counter and go to DATA. On `fall` with data=1, stay in IDLE with no error.
  - DATA: on `fall`, shift the bit in LSB-first and increment the counter. After the 8th bit, go to PARITY.
  - PARITY: on `fall`, compute ok = XOR(8 data bits, parity bit) == 1 (odd parity), then go to STOP.
  - STOP: on `fall`:
    - stop=1 and parity ok: push the byte.
    - stop=1 and parity bad: pulse `parity_err`.
    - stop=0: pulse `frame_err` (takes precedence over a parity failure).
    - In all cases return to IDLE.
- **Timeout:**
  - A cycle counter is cleared on every `fall` and counts while the FSM is not in IDLE.
  - When it reaches TIMEOUT, pulse `frame_err`, go to IDLE and discard the partial byte.
- **FIFO:**
  - Circular buffer with write/read pointers FIFO_LOG2+1 bits wide. Full/empty are decided by the MSB difference.
  - `rd_data` is the head entry, read combinationally from the registered memory.
  - Push while full: byte dropped, `overflow` set.
  - Push and pop in the same cycle while full: both happen; no overflow.
  - Push and pop in the same cycle while empty: only the push happens (the pop is ignored).
- **Reset** (synchronous, any cycle, including mid-frame):
  - FSM to IDLE, all counters to 0, FIFO emptied.
  - `rd_valid`=0, `rd_data`=0, `parity_err`=0, `frame_err`=0, `overflow`=0, filtered clock=1.
  - A frame already in progress at reset is lost. The first `fall` after reset is interpreted as a start bit only if data=0.

## Timing
- Filter latency: the filtered clock changes FILTER_LEN+2 cycles after a raw pad transition that stays stable.
- Byte latency: `rd_valid` rises exactly FILTER_LEN+4 cycles after the raw falling edge of the stop-bit clock.
- Error pulses are aligned to the cycle in which that push would have occurred.
- Pop timing: `rd_ack` with `rd_valid`=1 advances the head. New `rd_data` and `rd_valid` are visible the next cycle.
- Back-to-back pops: allowed every cycle.
- Glitch rejection: any clock glitch shorter than FILTER_LEN cycles produces no `fall`.
- Minimum PS/2 clock period supported: 2·(FILTER_LEN+2) cycles. Actual PS/2 clocks (≥60 µs, i.e. 1500 cycles) exceed this by far.

## Test plan
- **Good byte:** frame 0x1C with parity bit 0 (sent as 0,0,0,1,1,1,0,0,0,0,1; LSB first), PS/2 clock 80 µs → `rd_valid`=1 and `rd_data`=0x1C exactly FILTER_LEN+4 cycles after the stop-bit falling edge; `rd_ack` → `rd_valid`=0.
- **Two frames, no pops:** 0xF0 (parity bit 1) then 0x1C → FIFO holds both; successive pops return 0xF0 then 0x1C; no error pulses.
- **Bad parity:** 0x1C with parity bit 1 → one `parity_err` pulse, `rd_valid` stays 0. Bad stop bit (0) on a good 0x1C → one `frame_err` pulse, no push.
- **Timeout:** start bit plus 3 data bits, then the clock is held high → `frame_err` pulse TIMEOUT cycles after the last `fall`; a following good 0x5A frame is received correctly.
- **Overflow:** five good frames 0x01..0x05 with no reads → `overflow`=1; pops return 0x01..0x04 only. Then assert `reset` → `overflow`=0 and `rd_valid`=0.
- **Glitch and reset mid-frame:**
  - A 3-cycle low pulse on `ps2_clk_in` while idle → no state change.
  - `reset` asserted after 4 data bits → no push. The next full 0x1C frame is received correctly.
